spi_matrix_column_tx: RTL and testbench

- Parametrised successor to the multi-channel SPI output stage of the LED-matrix driver path.
- Serialises one SPI_SIZE-bit word per channel in parallel on CHANNEL_NUMBER MOSI lines with a shared SPI clock.
- Drives the column-select 74HC595-style shift register (ser_clk/ser_data/ser_stcp/ser_n_enable).
- Adds over the previous generation: programmable SPI clock divider, column wrap counter, blanking window, and an optional appended extra bit.

---
 rtl/spi_matrix_column_tx.sv | 243 ++++++++++++++++++++++++
 tb/tb_spi_matrix_column_tx.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_matrix_column_tx.sv
// spi_matrix_column_tx
// Multi-lane SPI output stage for the LED-matrix driver. One SPI_SIZE-bit word
// per lane is shifted out in parallel on CHANNEL_NUMBER MOSI lines sharing a
// single mode-0 SPI clock. Before the data, an optional column step drives the
// 74HC595-style column-select register: one serial shift, a storage latch, and
// then a blanking window with the column outputs disabled.
//
// Ports
//   clk_i                 system clock
//   rst_i                 synchronous active-high reset
//   data_in_i             lane c word in bits [c*SPI_SIZE +: SPI_SIZE]
//   start_first_column_i  select column 0, then send the word
//   start_next_column_i   advance one column (wrapping), then send the word
//   next_data_i           send the word without touching the column register
//   extra_bit_i           appended as the last bit when EXTRA_BIT_EN=1
//   tx_finish_o           high while idle and ready for a command
//   column_index_o        column currently latched in the select register
//   spi_clk_o/spi_mosi_o  shared SPI clock and per-lane data
//   ser_clk_o/ser_data_o  column register shift clock and serial input
//   ser_stcp_o            column register storage latch
//   ser_n_enable_o        active-low column output enable
`timescale 1ns/1ps
module spi_matrix_column_tx #(
    parameter int CHANNEL_NUMBER = 3,
    parameter int SPI_SIZE       = 8,
    parameter int MSB_FIRST      = 1,
    parameter int CLK_DIV        = 2,
    parameter int COLUMN_COUNT   = 16,
    parameter int BLANK_CYCLES   = 4,
    parameter int EXTRA_BIT_EN   = 0
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic [CHANNEL_NUMBER*SPI_SIZE-1:0] data_in_i,
    input  logic                               start_first_column_i,
    input  logic                               start_next_column_i,
    input  logic                               next_data_i,
    input  logic                               extra_bit_i,
    output logic                               tx_finish_o,
    output logic [$clog2(COLUMN_COUNT)-1:0]    column_index_o,
    output logic                               spi_clk_o,
    output logic [CHANNEL_NUMBER-1:0]          spi_mosi_o,
    output logic                               ser_clk_o,
    output logic                               ser_data_o,
    output logic                               ser_stcp_o,
    output logic                               ser_n_enable_o
);

    localparam int NBITS      = SPI_SIZE + EXTRA_BIT_EN;
    localparam int COL_W      = $clog2(COLUMN_COUNT);
    localparam int BIT_W      = (NBITS > 1) ? $clog2(NBITS) : 1;
    localparam int CNT_MAX    = (2 * CLK_DIV > BLANK_CYCLES) ? 2 * CLK_DIV : BLANK_CYCLES;
    localparam int CNT_W      = $clog2(CNT_MAX + 1);
    localparam int BLANK_LAST = (BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0;

    localparam logic [CNT_W-1:0] HALF_END  = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] FULL_END  = CNT_W'(2 * CLK_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_LAST);
    localparam logic [BIT_W-1:0] BIT_END   = BIT_W'(NBITS - 1);
    localparam logic [COL_W-1:0] COL_END   = COL_W'(COLUMN_COUNT - 1);

    typedef enum logic [2:0] {IDLE, COL_SHIFT, COL_LATCH, BLANK, DATA} state_t;

    state_t                                state_q, state_d;
    logic [CNT_W-1:0]                      cnt_q, cnt_d;
    logic [BIT_W-1:0]                      bit_q, bit_d;
    logic [COL_W-1:0]                      column_q, column_d;
    logic [COL_W-1:0]                      col_next_q, col_next_d;
    logic [CHANNEL_NUMBER-1:0][NBITS-1:0]  seq_q, seq_d;
    logic                                  spi_clk_q, spi_clk_d;
    logic [CHANNEL_NUMBER-1:0]             mosi_q, mosi_d;
    logic                                  ser_clk_q, ser_clk_d;
    logic                                  ser_data_q, ser_data_d;
    logic                                  ser_stcp_q, ser_stcp_d;
    logic                                  ser_n_en_q, ser_n_en_d;

    logic [CHANNEL_NUMBER-1:0][NBITS-1:0]  load_seq;
    logic [CHANNEL_NUMBER-1:0][NBITS-1:0]  seq_shift;
    logic [CHANNEL_NUMBER-1:0]             first_loaded;
    logic [CHANNEL_NUMBER-1:0]             first_stored;
    logic [CHANNEL_NUMBER-1:0]             next_bits;

    // Each lane's word is rearranged into transmit order so the top bit is
    // always the one on the wire; the extra bit sits at the bottom so it goes last.
    always_comb begin
        load_seq     = '0;
        seq_shift    = '0;
        first_loaded = '0;
        first_stored = '0;
        next_bits    = '0;
        for (int c = 0; c < CHANNEL_NUMBER; c++) begin
            for (int b = 0; b < SPI_SIZE; b++) begin
                if (MSB_FIRST != 0)
                    load_seq[c][NBITS-1-b] = data_in_i[c*SPI_SIZE + SPI_SIZE-1-b];
                else
                    load_seq[c][NBITS-1-b] = data_in_i[c*SPI_SIZE + b];
            end
            if (EXTRA_BIT_EN != 0)
                load_seq[c][0] = extra_bit_i;
            seq_shift[c]    = seq_q[c] << 1;
            first_loaded[c] = load_seq[c][NBITS-1];
            first_stored[c] = seq_q[c][NBITS-1];
            next_bits[c]    = seq_shift[c][NBITS-1];
        end
    end

    // Sequencer. All outputs are registered; cnt_q counts clk cycles within the
    // current phase and is cleared on every state change.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + CNT_W'(1);
        bit_d      = bit_q;
        column_d   = column_q;
        col_next_d = col_next_q;
        seq_d      = seq_q;
        spi_clk_d  = spi_clk_q;
        mosi_d     = mosi_q;
        ser_clk_d  = ser_clk_q;
        ser_data_d = ser_data_q;
        ser_stcp_d = ser_stcp_q;
        ser_n_en_d = ser_n_en_q;

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (start_first_column_i || start_next_column_i) begin
                    // A step past the last column wraps by injecting a fresh 1.
                    if (start_first_column_i || column_q == COL_END) begin
                        ser_data_d = 1'b1;
                        col_next_d = '0;
                    end else begin
                        ser_data_d = 1'b0;
                        col_next_d = column_q + COL_W'(1);
                    end
                    ser_clk_d  = 1'b0;
                    ser_n_en_d = 1'b1;
                    seq_d      = load_seq;
                    state_d    = COL_SHIFT;
                end else if (next_data_i) begin
                    seq_d     = load_seq;
                    mosi_d    = first_loaded;
                    spi_clk_d = 1'b0;
                    bit_d     = '0;
                    state_d   = DATA;
                end
            end
            COL_SHIFT: begin
                if (cnt_q == HALF_END)
                    ser_clk_d = 1'b1;
                if (cnt_q == FULL_END) begin
                    ser_clk_d  = 1'b0;
                    ser_stcp_d = 1'b1;
                    cnt_d      = '0;
                    state_d    = COL_LATCH;
                end
            end
            COL_LATCH: begin
                if (cnt_q == HALF_END) begin
                    ser_stcp_d = 1'b0;
                    column_d   = col_next_q;
                    cnt_d      = '0;
                    if (BLANK_CYCLES == 0) begin
                        ser_n_en_d = 1'b0;
                        mosi_d     = first_stored;
                        spi_clk_d  = 1'b0;
                        bit_d      = '0;
                        state_d    = DATA;
                    end else begin
                        state_d = BLANK;
                    end
                end
            end
            BLANK: begin
                if (cnt_q == BLANK_END) begin
                    ser_n_en_d = 1'b0;
                    mosi_d     = first_stored;
                    spi_clk_d  = 1'b0;
                    bit_d      = '0;
                    cnt_d      = '0;
                    state_d    = DATA;
                end
            end
            DATA: begin
                if (cnt_q == HALF_END)
                    spi_clk_d = 1'b1;
                if (cnt_q == FULL_END) begin
                    spi_clk_d = 1'b0;
                    cnt_d     = '0;
                    if (bit_q == BIT_END) begin
                        mosi_d  = '0;
                        state_d = IDLE;
                    end else begin
                        bit_d  = bit_q + BIT_W'(1);
                        seq_d  = seq_shift;
                        mosi_d = next_bits;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            column_q   <= '0;
            col_next_q <= '0;
            seq_q      <= '0;
            spi_clk_q  <= 1'b0;
            mosi_q     <= '0;
            ser_clk_q  <= 1'b0;
            ser_data_q <= 1'b0;
            ser_stcp_q <= 1'b0;
            ser_n_en_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            column_q   <= column_d;
            col_next_q <= col_next_d;
            seq_q      <= seq_d;
            spi_clk_q  <= spi_clk_d;
            mosi_q     <= mosi_d;
            ser_clk_q  <= ser_clk_d;
            ser_data_q <= ser_data_d;
            ser_stcp_q <= ser_stcp_d;
            ser_n_en_q <= ser_n_en_d;
        end
    end

    assign tx_finish_o    = (state_q == IDLE);
    assign column_index_o = column_q;
    assign spi_clk_o      = spi_clk_q;
    assign spi_mosi_o     = mosi_q;
    assign ser_clk_o      = ser_clk_q;
    assign ser_data_o     = ser_data_q;
    assign ser_stcp_o     = ser_stcp_q;
    assign ser_n_enable_o = ser_n_en_q;

endmodule

// File: tb/tb_spi_matrix_column_tx.sv
// tb_spi_matrix_column_tx
// Directed bench for spi_matrix_column_tx. Three instances cover the default
// configuration (0), LSB-first (1) and the appended extra bit (2); clock, reset
// and data are shared, commands are per instance and sel picks the one watched.
`timescale 1ns/1ps
module tb_spi_matrix_column_tx;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [23:0]      dataIn = '0;
    logic [2:0]       startFirst = '0;
    logic [2:0]       startNext = '0;
    logic [2:0]       nextData = '0;
    logic [2:0]       extraBit = '0;
    logic [2:0]       txFinishW, spiClkW, serClkW, serDataW, serStcpW, serNEnW;
    logic [2:0][2:0]  mosiW;
    logic [2:0][3:0]  colW;

    int sel = 0;
    int assertCount = 0;
    int failCount = 0;

    int         monBusy, monSpi, monSerClk, monStcp;
    logic       monSerData, monNen;
    logic [2:0] monBits [0:15];

    // 10 ns system clock
    always #5 clk = ~clk;

    spi_matrix_column_tx dutA (
        .clk_i(clk), .rst_i(rst), .data_in_i(dataIn),
        .start_first_column_i(startFirst[0]), .start_next_column_i(startNext[0]),
        .next_data_i(nextData[0]), .extra_bit_i(extraBit[0]),
        .tx_finish_o(txFinishW[0]), .column_index_o(colW[0]),
        .spi_clk_o(spiClkW[0]), .spi_mosi_o(mosiW[0]),
        .ser_clk_o(serClkW[0]), .ser_data_o(serDataW[0]),
        .ser_stcp_o(serStcpW[0]), .ser_n_enable_o(serNEnW[0]));

    spi_matrix_column_tx #(.MSB_FIRST(0)) dutB (
        .clk_i(clk), .rst_i(rst), .data_in_i(dataIn),
        .start_first_column_i(startFirst[1]), .start_next_column_i(startNext[1]),
        .next_data_i(nextData[1]), .extra_bit_i(extraBit[1]),
        .tx_finish_o(txFinishW[1]), .column_index_o(colW[1]),
        .spi_clk_o(spiClkW[1]), .spi_mosi_o(mosiW[1]),
        .ser_clk_o(serClkW[1]), .ser_data_o(serDataW[1]),
        .ser_stcp_o(serStcpW[1]), .ser_n_enable_o(serNEnW[1]));

    spi_matrix_column_tx #(.EXTRA_BIT_EN(1)) dutC (
        .clk_i(clk), .rst_i(rst), .data_in_i(dataIn),
        .start_first_column_i(startFirst[2]), .start_next_column_i(startNext[2]),
        .next_data_i(nextData[2]), .extra_bit_i(extraBit[2]),
        .tx_finish_o(txFinishW[2]), .column_index_o(colW[2]),
        .spi_clk_o(spiClkW[2]), .spi_mosi_o(mosiW[2]),
        .ser_clk_o(serClkW[2]), .ser_data_o(serDataW[2]),
        .ser_stcp_o(serStcpW[2]), .ser_n_enable_o(serNEnW[2]));

    // Pulse the chosen commands for one clock on the selected instance; returns
    // one time unit after the accepting edge.
    task automatic issue(input logic f, input logic n, input logic d);
        startFirst[sel] = f;
        startNext[sel]  = n;
        nextData[sel]   = d;
        @(posedge clk); #1;
        startFirst[sel] = 1'b0;
        startNext[sel]  = 1'b0;
        nextData[sel]   = 1'b0;
    endtask

    // Follows the selected instance until tx_finish returns (bounded), counting
    // busy cycles and clock rises and capturing the lanes at each spi_clk rise.
    // At busy cycle injectAt every command input is raised for one cycle.
    task automatic monitor(input int injectAt);
        logic prevSpi, prevSer, prevStcp;
        int   guard;
        monBusy = 0; monSpi = 0; monSerClk = 0; monStcp = 0;
        monSerData = 1'b0; monNen = 1'b1;
        prevSpi = 1'b0; prevSer = 1'b0; prevStcp = 1'b0; guard = 0;
        for (int i = 0; i < 16; i++) monBits[i] = '0;
        while (txFinishW[sel] !== 1'b1 && guard < 500) begin
            if (monBusy == injectAt) begin
                startFirst[sel] = 1'b1; startNext[sel] = 1'b1; nextData[sel] = 1'b1;
            end else begin
                startFirst[sel] = 1'b0; startNext[sel] = 1'b0; nextData[sel] = 1'b0;
            end
            if (spiClkW[sel] && !prevSpi) begin
                if (monSpi < 16) monBits[monSpi] = mosiW[sel];
                if (monSpi == 0) monNen = serNEnW[sel];
                monSpi++;
            end
            if (serClkW[sel] && !prevSer) begin
                monSerClk++;
                monSerData = serDataW[sel];
            end
            if (serStcpW[sel] && !prevStcp) monStcp++;
            prevSpi = spiClkW[sel]; prevSer = serClkW[sel]; prevStcp = serStcpW[sel];
            monBusy++; guard++;
            @(posedge clk); #1;
        end
        startFirst[sel] = 1'b0; startNext[sel] = 1'b0; nextData[sel] = 1'b0;
    endtask

    task automatic test_reset_initial;
        sel = 0;
        assertCount++; if (txFinishW !== 3'b111) begin failCount++; $display("[TB] FAIL init_tx_finish: got %b expected 111", txFinishW); end
        assertCount++; if (colW[0] !== 4'd0) begin failCount++; $display("[TB] FAIL init_column: got %0d expected 0", colW[0]); end
        assertCount++; if (serNEnW[0] !== 1'b1) begin failCount++; $display("[TB] FAIL init_n_enable: got %b expected 1", serNEnW[0]); end
        assertCount++; if (spiClkW[0] !== 1'b0) begin failCount++; $display("[TB] FAIL init_spi_clk: got %b expected 0", spiClkW[0]); end
        assertCount++; if (mosiW[0] !== 3'b000) begin failCount++; $display("[TB] FAIL init_mosi: got %b expected 000", mosiW[0]); end
    endtask

    task automatic test_first_column;
        sel = 0;
        dataIn = 24'h0F0F0F;
        issue(1'b1, 1'b0, 1'b0);
        monitor(-1);
        assertCount++; if (monBusy !== 42) begin failCount++; $display("[TB] FAIL first_busy: got %0d expected 42", monBusy); end
        assertCount++; if (monSerClk !== 1) begin failCount++; $display("[TB] FAIL first_ser_clk_pulses: got %0d expected 1", monSerClk); end
        assertCount++; if (monSerData !== 1'b1) begin failCount++; $display("[TB] FAIL first_ser_data: got %b expected 1", monSerData); end
        assertCount++; if (monStcp !== 1) begin failCount++; $display("[TB] FAIL first_stcp_pulses: got %0d expected 1", monStcp); end
        assertCount++; if (monSpi !== 8) begin failCount++; $display("[TB] FAIL first_spi_pulses: got %0d expected 8", monSpi); end
        assertCount++; if (monNen !== 1'b0) begin failCount++; $display("[TB] FAIL first_n_enable_in_data: got %b expected 0", monNen); end
        for (int i = 0; i < 8; i++) begin
            assertCount++;
            if (monBits[i] !== ((i < 4) ? 3'b000 : 3'b111)) begin
                failCount++; $display("[TB] FAIL first_bit%0d: got %b expected %b", i, monBits[i], (i < 4) ? 3'b000 : 3'b111);
            end
        end
        assertCount++; if (colW[0] !== 4'd0) begin failCount++; $display("[TB] FAIL first_column: got %0d expected 0", colW[0]); end
        assertCount++; if (mosiW[0] !== 3'b000 || spiClkW[0] !== 1'b0) begin failCount++; $display("[TB] FAIL first_idle_lines: got mosi %b clk %b expected 000 0", mosiW[0], spiClkW[0]); end
    endtask

    task automatic test_lane_mapping;
        // lane0=0x81, lane1=0x3C, lane2=0xA5, MSB first, shown as {lane2,lane1,lane0}
        logic [2:0] expBits [0:7];
        expBits = '{3'b101, 3'b000, 3'b110, 3'b010, 3'b010, 3'b110, 3'b000, 3'b101};
        sel = 0;
        dataIn = 24'hA53C81;
        issue(1'b0, 1'b0, 1'b1);
        monitor(-1);
        assertCount++; if (monBusy !== 32) begin failCount++; $display("[TB] FAIL lanes_busy: got %0d expected 32", monBusy); end
        for (int i = 0; i < 8; i++) begin
            assertCount++;
            if (monBits[i] !== expBits[i]) begin
                failCount++; $display("[TB] FAIL lanes_bit%0d: got %b expected %b", i, monBits[i], expBits[i]);
            end
        end
    endtask

    task automatic test_next_data;
        sel = 1;
        dataIn = 24'h000000;
        issue(1'b0, 1'b1, 1'b0);
        monitor(-1);
        assertCount++; if (colW[1] !== 4'd1) begin failCount++; $display("[TB] FAIL nd_setup_column: got %0d expected 1", colW[1]); end
        dataIn = 24'hF0F0F0;
        issue(1'b0, 1'b0, 1'b1);
        monitor(-1);
        assertCount++; if (monBusy !== 32) begin failCount++; $display("[TB] FAIL nd_busy: got %0d expected 32", monBusy); end
        assertCount++; if (monSerClk !== 0 || monStcp !== 0) begin failCount++; $display("[TB] FAIL nd_no_column_activity: got ser_clk %0d stcp %0d expected 0 0", monSerClk, monStcp); end
        assertCount++; if (colW[1] !== 4'd1) begin failCount++; $display("[TB] FAIL nd_column: got %0d expected 1", colW[1]); end
        assertCount++; if (serNEnW[1] !== 1'b0) begin failCount++; $display("[TB] FAIL nd_n_enable: got %b expected 0", serNEnW[1]); end
        assertCount++; if (monSpi !== 8) begin failCount++; $display("[TB] FAIL nd_spi_pulses: got %0d expected 8", monSpi); end
        for (int i = 0; i < 8; i++) begin
            assertCount++;
            if (monBits[i] !== ((i < 4) ? 3'b000 : 3'b111)) begin
                failCount++; $display("[TB] FAIL nd_bit%0d: got %b expected %b", i, monBits[i], (i < 4) ? 3'b000 : 3'b111);
            end
        end
    endtask

    task automatic test_extra_bit;
        sel = 2;
        dataIn = 24'h000000;
        extraBit[2] = 1'b1;
        issue(1'b0, 1'b0, 1'b1);
        extraBit[2] = 1'b0;
        monitor(-1);
        assertCount++; if (monBusy !== 36) begin failCount++; $display("[TB] FAIL extra_busy: got %0d expected 36", monBusy); end
        assertCount++; if (monSpi !== 9) begin failCount++; $display("[TB] FAIL extra_spi_pulses: got %0d expected 9", monSpi); end
        for (int i = 0; i < 9; i++) begin
            assertCount++;
            if (monBits[i] !== ((i == 8) ? 3'b111 : 3'b000)) begin
                failCount++; $display("[TB] FAIL extra_bit%0d: got %b expected %b", i, monBits[i], (i == 8) ? 3'b111 : 3'b000);
            end
        end
    endtask

    task automatic test_column_walk;
        sel = 0;
        dataIn = 24'h123456;
        for (int j = 1; j <= 16; j++) begin
            issue(1'b0, 1'b1, 1'b0);
            monitor(-1);
            assertCount++; if (colW[0] !== 4'(j % 16)) begin failCount++; $display("[TB] FAIL walk_column_step%0d: got %0d expected %0d", j, colW[0], j % 16); end
            assertCount++; if (monSerData !== ((j == 16) ? 1'b1 : 1'b0)) begin failCount++; $display("[TB] FAIL walk_ser_data_step%0d: got %b expected %b", j, monSerData, (j == 16) ? 1'b1 : 1'b0); end
            assertCount++; if (monSerClk !== 1) begin failCount++; $display("[TB] FAIL walk_ser_clk_step%0d: got %0d expected 1", j, monSerClk); end
        end
    endtask

    task automatic test_priority;
        sel = 0;
        issue(1'b0, 1'b1, 1'b1);
        monitor(-1);
        assertCount++; if (monSerClk !== 1) begin failCount++; $display("[TB] FAIL prio_next_shift: got %0d expected 1", monSerClk); end
        assertCount++; if (colW[0] !== 4'd1) begin failCount++; $display("[TB] FAIL prio_next_column: got %0d expected 1", colW[0]); end
        assertCount++; if (monSerData !== 1'b0) begin failCount++; $display("[TB] FAIL prio_next_ser_data: got %b expected 0", monSerData); end
        issue(1'b1, 1'b1, 1'b0);
        monitor(-1);
        assertCount++; if (colW[0] !== 4'd0) begin failCount++; $display("[TB] FAIL prio_first_column: got %0d expected 0", colW[0]); end
        assertCount++; if (monSerData !== 1'b1) begin failCount++; $display("[TB] FAIL prio_first_ser_data: got %b expected 1", monSerData); end
    endtask

    task automatic test_busy_ignore;
        sel = 0;
        issue(1'b0, 1'b0, 1'b1);
        monitor(10);
        assertCount++; if (monSpi !== 8) begin failCount++; $display("[TB] FAIL busy_spi_pulses: got %0d expected 8", monSpi); end
        assertCount++; if (monBusy !== 32) begin failCount++; $display("[TB] FAIL busy_window: got %0d expected 32", monBusy); end
        assertCount++; if (monSerClk !== 0) begin failCount++; $display("[TB] FAIL busy_ser_clk: got %0d expected 0", monSerClk); end
        assertCount++; if (colW[0] !== 4'd0) begin failCount++; $display("[TB] FAIL busy_column: got %0d expected 0", colW[0]); end
        repeat (3) begin @(posedge clk); #1; end
        assertCount++; if (txFinishW[0] !== 1'b1) begin failCount++; $display("[TB] FAIL busy_stays_idle: got %b expected 1", txFinishW[0]); end
    endtask

    task automatic test_reset;
        sel = 0;
        issue(1'b0, 1'b1, 1'b0);
        monitor(-1);
        issue(1'b0, 1'b1, 1'b0);
        repeat (19) begin @(posedge clk); #1; end
        assertCount++; if (colW[0] !== 4'd2 || txFinishW[0] !== 1'b0) begin failCount++; $display("[TB] FAIL rst_pre_state: got col %0d finish %b expected 2 0", colW[0], txFinishW[0]); end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        assertCount++; if (spiClkW[0] !== 1'b0) begin failCount++; $display("[TB] FAIL rst_spi_clk: got %b expected 0", spiClkW[0]); end
        assertCount++; if (mosiW[0] !== 3'b000) begin failCount++; $display("[TB] FAIL rst_mosi: got %b expected 000", mosiW[0]); end
        assertCount++; if (serClkW[0] !== 1'b0 || serDataW[0] !== 1'b0 || serStcpW[0] !== 1'b0) begin failCount++; $display("[TB] FAIL rst_ser_lines: got clk %b data %b stcp %b expected 0 0 0", serClkW[0], serDataW[0], serStcpW[0]); end
        assertCount++; if (serNEnW[0] !== 1'b1) begin failCount++; $display("[TB] FAIL rst_n_enable: got %b expected 1", serNEnW[0]); end
        assertCount++; if (txFinishW[0] !== 1'b1) begin failCount++; $display("[TB] FAIL rst_tx_finish: got %b expected 1", txFinishW[0]); end
        assertCount++; if (colW[0] !== 4'd0) begin failCount++; $display("[TB] FAIL rst_column: got %0d expected 0", colW[0]); end
    endtask

    // Scenario sequence
    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        $display("[TB] starting directed scenarios");
        test_reset_initial;
        test_first_column;
        test_lane_mapping;
        test_next_data;
        test_extra_bit;
        test_column_walk;
        test_priority;
        test_busy_ignore;
        test_reset;
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
